// File: rtl/dff.sv
//==============================================================================
// Module   : dff
// Purpose  : Two-stage rising-edge D-type register chain (D -> Q1 -> Q2) with
//            asynchronous active-low reset.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2
);

    // Both stages update on the same edge; Q2 takes Q1's pre-edge value, so
    // D reaches Q2 only after two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q1 <= '0;
            Q2 <= '0;
        end else begin
            Q1 <= D;
            Q2 <= Q1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dff.sv
//==============================================================================
// Module   : tb_dff
// Purpose  : Self-checking bench for dff at WIDTH=8 (vector table, timed
//            corner sequences, randomized run against a history-queue model).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dff;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q1;
    logic [WIDTH-1:0] Q2;

    int checks = 0;
    int errors = 0;

    dff #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D),
        .Q1    (Q1),
        .Q2    (Q2)
    );

    // 20 ns period, first rising edge at 10 ns
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: the last two D values sampled since reset.
    logic [WIDTH-1:0] hist[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
        end else begin
            hist.push_back(D);
            if (hist.size() > 2) void'(hist.pop_front());
        end
    end

    function automatic logic [WIDTH-1:0] model_q1();
        return (hist.size() >= 1) ? hist[hist.size()-1] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] model_q2();
        return (hist.size() >= 2) ? hist[hist.size()-2] : '0;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic             rst_n;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] q1;
        logic [WIDTH-1:0] q2;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Reset held with D toggling, release with D=FF, width patterns,
        // then a mid-stream reset and a fresh start.
        vecs[0]  = '{1'b0, 8'hFF, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 8'hFF, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 8'hFF, 8'hFF, 8'h00};
        vecs[4]  = '{1'b1, 8'hFF, 8'hFF, 8'hFF};
        vecs[5]  = '{1'b1, 8'hA5, 8'hA5, 8'hFF};
        vecs[6]  = '{1'b1, 8'hA5, 8'hA5, 8'hA5};
        vecs[7]  = '{1'b1, 8'h5A, 8'h5A, 8'hA5};
        vecs[8]  = '{1'b1, 8'h3C, 8'h3C, 8'h5A};
        vecs[9]  = '{1'b0, 8'h77, 8'h00, 8'h00};
        vecs[10] = '{1'b1, 8'h81, 8'h81, 8'h00};

        rst_n = 1'b0;
        D     = '0;
        #3;
        check("reset_q1", Q1, 8'h00);
        check("reset_q2", Q2, 8'h00);

        // Table-driven vectors: apply mid-cycle, check 5 ns after the edge
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            D     = vecs[i].d;
            @(posedge clk);
            #5;
            check($sformatf("vec%0d_q1", i), Q1, vecs[i].q1);
            check($sformatf("vec%0d_q2", i), Q2, vecs[i].q2);
        end

        // Pipeline timing: T is the edge corresponding to 10 ns
        @(negedge clk);
        rst_n = 1'b0;
        D     = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #30 D = 8'h01;                            // 40 ns
        #5  check("pipe45_q1", Q1, 8'h00);
            check("pipe45_q2", Q2, 8'h00);
        #6  check("pipe51_q1", Q1, 8'h01);
            check("pipe51_q2", Q2, 8'h00);
        #9  D = 8'h00;                            // 60 ns
        #11 check("pipe71_q1", Q1, 8'h00);
            check("pipe71_q2", Q2, 8'h01);
        #9  D = 8'h01;                            // 80 ns
        #11 check("pipe91_q1", Q1, 8'h01);
            check("pipe91_q2", Q2, 8'h00);
        #20 check("pipe111_q1", Q1, 8'h01);
            check("pipe111_q2", Q2, 8'h01);

        // Mid-cycle glitch on D must not disturb the outputs
        @(negedge clk);
        D = 8'hC3;
        @(posedge clk);
        @(posedge clk);
        #5  D = 8'h3C;
        #3  D = 8'hC3;
        #5  check("glitch_q1", Q1, 8'hC3);
            check("glitch_q2", Q2, 8'hC3);
        @(posedge clk);
        #5  check("glitch_next_q1", Q1, 8'hC3);
            check("glitch_next_q2", Q2, 8'hC3);

        // Asynchronous reset 5 ns after an edge clears before the next edge
        @(posedge clk);
        #5 rst_n = 1'b0;
        #1 check("async_rst_q1", Q1, 8'h00);
           check("async_rst_q2", Q2, 8'h00);
        #8 check("async_hold_q1", Q1, 8'h00);
           check("async_hold_q2", Q2, 8'h00);

        // Randomized run against the history model
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            D     = WIDTH'($urandom);
            rst_n = ($urandom_range(0, 15) != 0);
            @(posedge clk);
            #5;
            check("rand_q1", Q1, model_q1());
            check("rand_q2", Q2, model_q2());
            if (($urandom_range(0, 19) == 0) && rst_n) begin
                rst_n = 1'b0;
                #1;
                check("rand_async_q1", Q1, 8'h00);
                check("rand_async_q2", Q2, 8'h00);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
